// File: rtl/vx_tcu_tfr_acc_int_if.sv
`default_nettype none
// ============================================================================
// Module   : vx_tcu_tfr_acc_int_if
// Brief    : Beat-in / tile-out handshake bundle for the integer TCU accumulator.
// Revision : 1.0 - initial release
// ============================================================================
interface vx_tcu_tfr_acc_int_if #(
    parameter int TCK = 4
);
    logic                  valid_in;
    logic                  ready_in;
    logic [TCK-1:0][24:0]  prod_in;
    logic [31:0]           c_in;
    logic [31:0]           req_id_in;
    logic                  valid_out;
    logic                  ready_out;
    logic [31:0]           d_out;
    logic [31:0]           req_id_out;

    // master is the producer/consumer side, slave is the accumulator
    modport master (
        output valid_in, prod_in, c_in, req_id_in, ready_out,
        input  ready_in, valid_out, d_out, req_id_out
    );

    modport slave (
        input  valid_in, prod_in, c_in, req_id_in, ready_out,
        output ready_in, valid_out, d_out, req_id_out
    );
endinterface
`default_nettype wire

// File: rtl/vx_tcu_tfr_acc_int.sv
`default_nettype none
// ============================================================================
// Module   : vx_tcu_tfr_acc_int
// Brief    : Two-stage integer accumulator: lane reduction, then KSTEPS-beat
//            accumulation into one 32-bit tile result. Define TCU_ACC_SAT_EN
//            for signed saturating accumulation (default wraps mod 2^32).
// Revision : 1.0 - initial release
// ============================================================================
module vx_tcu_tfr_acc_int #(
    parameter int TCK    = 4,
    parameter int KSTEPS = 4
) (
    input  wire logic             clk,
    input  wire logic             reset,
    vx_tcu_tfr_acc_int_if.slave   bus
);
    localparam int             CW   = (KSTEPS > 1) ? $clog2(KSTEPS) : 1;
    localparam logic [CW-1:0]  LAST = CW'(KSTEPS - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] HOLD  = 2'd3;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          drain_cnt;
    logic          ready;
    logic          accept;
    logic          first_beat;
    logic          last_beat;

    logic [31:0]   lane_sum;
    logic          s1_valid;
    logic          s1_first;
    logic [31:0]   s1_sum;
    logic [31:0]   s1_seed;
    logic [31:0]   s1_id;

    logic [31:0]   acc;
    logic [31:0]   acc_base;
    logic [31:0]   acc_next;
    logic [31:0]   tile_id;
    logic [31:0]   d_out_q;
    logic [31:0]   id_out_q;

    assign ready      = ((state == IDLE) || (state == ACCUM)) && !reset;
    assign accept     = bus.valid_in && ready;
    assign first_beat = (cnt == '0);
    assign last_beat  = (cnt == LAST);

    always_comb begin
        lane_sum = '0;
        for (int i = 0; i < TCK; i++) begin
            lane_sum = lane_sum + {{7{bus.prod_in[i][24]}}, bus.prod_in[i]};
        end
    end

    assign acc_base = s1_first ? s1_seed : acc;

`ifdef TCU_ACC_SAT_EN
    logic [32:0] acc_wide;
    assign acc_wide = {acc_base[31], acc_base} + {s1_sum[31], s1_sum};
    // Bits 32 and 31 disagree only on signed overflow; bit 32 is the true sign.
    always_comb begin
        acc_next = acc_wide[31:0];
        if (acc_wide[32] != acc_wide[31]) begin
            acc_next = acc_wide[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end
    end
`else
    assign acc_next = acc_base + s1_sum;
`endif

    // Stage 1: lane reduction plus first-beat seed/tag capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_first <= 1'b0;
            s1_sum   <= '0;
            s1_seed  <= '0;
            s1_id    <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_sum   <= lane_sum;
                s1_first <= first_beat;
                if (first_beat) begin
                    s1_seed <= bus.c_in;
                    s1_id   <= bus.req_id_in;
                end
            end
        end
    end

    // Stage 2: accumulate
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc     <= '0;
            tile_id <= '0;
        end else if (s1_valid) begin
            acc <= acc_next;
            if (s1_first) begin
                tile_id <= s1_id;
            end
        end
    end

    // Tile control; the final stage-2 write lands one cycle into DRAIN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            drain_cnt <= 1'b0;
            d_out_q   <= '0;
            id_out_q  <= '0;
        end else begin
            if (accept) begin
                cnt <= last_beat ? '0 : cnt + 1'b1;
            end
            case (state)
                IDLE, ACCUM: begin
                    if (accept && last_beat) begin
                        state     <= DRAIN;
                        drain_cnt <= 1'b0;
                    end else if (accept) begin
                        state <= ACCUM;
                    end
                end
                DRAIN: begin
                    if (drain_cnt) begin
                        state    <= HOLD;
                        d_out_q  <= acc;
                        id_out_q <= tile_id;
                    end
                    drain_cnt <= 1'b1;
                end
                HOLD: begin
                    if (bus.ready_out) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ready_in   = ready;
    assign bus.valid_out  = (state == HOLD);
    assign bus.d_out      = d_out_q;
    assign bus.req_id_out = id_out_q;
endmodule
`default_nettype wire

// File: doc/vx_tcu_tfr_acc_int.md
VX_TCU_TFR_ACC_INT -- requirements
Module: VX_tcu_tfr_acc_int

Interface
REQ-001 SHALL have parameter TCK, default 4: lanes of 25-bit integer partial products per beat.
REQ-002 SHALL have parameter KSTEPS, default 4: beats accumulated per output tile element, legal range >=1.
REQ-003 SHALL have port clk, input, 1: the single clock.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port valid_in, input, 1: beat present.
REQ-006 SHALL have port ready_in, output, 1: beat accepted this cycle when high with valid_in.
REQ-007 SHALL have port prod_in, input, TCK x 25: per-lane partial sums from the integer multiplier stage.
REQ-008 SHALL have port c_in, input, 32: accumulator seed, sampled on the first beat of a tile.
REQ-009 SHALL have port req_id_in, input, 32: tag, sampled on the first beat.
REQ-010 SHALL have port valid_out, output, 1: d_out valid.
REQ-011 SHALL have port ready_out, input, 1: downstream accepts d_out.
REQ-012 SHALL have port d_out, output, 32: accumulated signed result.
REQ-013 SHALL have port req_id_out, output, 32: tag of the tile on d_out.

Function
REQ-014 SHALL sign-extend each prod_in lane from 25 to 32 bits and sum all lanes modulo 2^32 into a stage-1 register one cycle after acceptance.
REQ-015 SHALL keep a beat counter cnt in 0..KSTEPS-1, incremented on each accept, wrapping to 0 after KSTEPS-1.
REQ-016 SHALL in stage 2 compute acc = (first beat ? c_in : acc) + lane_sum, where first beat means cnt==0 at acceptance; with KSTEPS=1 each beat is both first and last.
REQ-017 SHALL implement states IDLE (cnt==0, no tile open), ACCUM (tile open), DRAIN (last beat in pipeline), HOLD (result presented).
REQ-018 SHALL transition IDLE->ACCUM on a first-beat accept with KSTEPS>1, IDLE/ACCUM->DRAIN on the accept of beat KSTEPS-1, DRAIN->HOLD after exactly 2 cycles, HOLD->IDLE on valid_out&&ready_out.
REQ-019 SHALL drive ready_in high only in IDLE and ACCUM and never while reset is asserted.
REQ-020 SHALL assert valid_out exactly in HOLD, i.e. from the third rising edge after the last beat is accepted.
REQ-021 SHALL hold d_out and req_id_out stable while valid_out is high and ready_out is low.
REQ-022 SHALL tolerate any number of idle cycles between beats of a tile without changing the result.
REQ-023 SHALL ignore prod_in, c_in and req_id_in when no accept occurs.

Reset
REQ-024 SHALL on reset force state IDLE, cnt 0, acc 0, stage-1 register 0, valid_out 0, d_out 0, req_id_out 0, independent of clk.
REQ-025 SHALL discard any partially accumulated tile on reset mid-operation; the first accepted beat after reset starts a fresh tile.

Configuration
REQ-026 SHALL, when macro TCU_ACC_SAT_EN is defined, saturate every stage-2 addition to signed 32-bit range [0x80000000, 0x7FFFFFFF].
REQ-027 SHALL, when TCU_ACC_SAT_EN is undefined, wrap every stage-2 addition modulo 2^32 with no saturation logic.

Verification
REQ-028 SHALL cover: TCK=4, KSTEPS=4, all lanes 1, c_in=10, back-to-back beats -> d_out=26, valid_out rising 3 edges after last accept.
REQ-029 SHALL cover: all lanes 25'h1FFFFFF (-1), c_in=0, 4 beats -> d_out=0xFFFFFFF0.
REQ-030 SHALL cover: ready_out low 5 cycles in HOLD -> d_out/req_id_out stable, ready_in low, offered beats not accepted; tile consumed on first ready_out high.
REQ-031 SHALL cover: c_in=0x7FFFFFF0, all lanes 100, 4 beats -> d_out=0x7FFFFFFF with TCU_ACC_SAT_EN, 0x80000630 without.
REQ-032 SHALL cover: reset asserted after 2 beats of a tile -> valid_out 0 immediately; next 4-beat tile with lanes 2, c_in=0 -> d_out=32.
REQ-033 SHALL cover: 3-cycle valid_in gaps between beats and req_id_in=0xABCD on first beat only -> same d_out as back-to-back, req_id_out=0xABCD.
